sobel_edge_win3x3: RTL and testbench

//  Consumer of the 3x3 window stream produced by the line-buffer/window stage. Computes Sobel |Gx|+|Gy|
//  per window, thresholds it to a 1-bit edge pixel and suppresses invalid border windows.

---
 rtl/sobel_pkg.sv | 21 ++
 rtl/sobel_axis_grad.sv | 59 +++++
 rtl/sobel_edge_win3x3.sv | 176 +++++++++++++++++
 tb/tb_sobel_edge_win3x3.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared widths, limits and helpers for the Sobel edge stage
// Purpose : constants common to the gradient sub-module and the edge top.
// Ports   : none (package).
package sobel_pkg;

    localparam int PIX_W     = 10;
    localparam int SUM_W     = 12;
    localparam int MAG_W     = 13;
    localparam int MAG_OUT_W = 10;
    localparam int MAG_MAX   = 8184;

    // Clamp a full-range magnitude to the narrower output port width.
    function automatic logic [MAG_OUT_W-1:0] sat_mag(input logic [MAG_W-1:0] mag);
        if (mag > MAG_W'((1 << MAG_OUT_W) - 1)) begin
            sat_mag = '1;
        end else begin
            sat_mag = mag[MAG_OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sobel_axis_grad.sv
// rtl/sobel_axis_grad.sv - one Sobel axis: two 1-2-1 weighted sums then registered |difference|
// Purpose : S1 registers a0+2*a1+a2 and b0+2*b1+b2, S2 registers |sum_a - sum_b|.
// Ports   : clk, rst_n (async, active-low), i_clr (sync clear), i_en_s1 / i_en_s2 (stage
//           load enables), i_a0..i_a2 / i_b0..i_b2 (pixels), o_abs (S2 result).
module sobel_axis_grad
    import sobel_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en_s1,
    input  logic             i_en_s2,
    input  logic [PIX_W-1:0] i_a0,
    input  logic [PIX_W-1:0] i_a1,
    input  logic [PIX_W-1:0] i_a2,
    input  logic [PIX_W-1:0] i_b0,
    input  logic [PIX_W-1:0] i_b1,
    input  logic [PIX_W-1:0] i_b2,
    output logic [SUM_W-1:0] o_abs
);

    logic [SUM_W-1:0]        r_sum_a;
    logic [SUM_W-1:0]        r_sum_b;
    logic [SUM_W-1:0]        r_abs;
    logic [SUM_W-1:0]        w_sum_a;
    logic [SUM_W-1:0]        w_sum_b;
    logic signed [SUM_W:0]   w_diff;
    logic [SUM_W-1:0]        w_abs;

    assign w_sum_a = SUM_W'(i_a0) + SUM_W'({i_a1, 1'b0}) + SUM_W'(i_a2);
    assign w_sum_b = SUM_W'(i_b0) + SUM_W'({i_b1, 1'b0}) + SUM_W'(i_b2);

    // One extra bit keeps the signed difference exact; |diff| always fits back in SUM_W.
    assign w_diff = $signed({1'b0, r_sum_a}) - $signed({1'b0, r_sum_b});
    assign w_abs  = w_diff[SUM_W] ? SUM_W'(-w_diff) : w_diff[SUM_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_a <= '0;
            r_sum_b <= '0;
            r_abs   <= '0;
        end else if (i_clr) begin
            r_sum_a <= '0;
            r_sum_b <= '0;
            r_abs   <= '0;
        end else begin
            if (i_en_s1) begin
                r_sum_a <= w_sum_a;
                r_sum_b <= w_sum_b;
            end
            if (i_en_s2) begin
                r_abs <= w_abs;
            end
        end
    end

    assign o_abs = r_abs;

endmodule

// File: rtl/sobel_edge_win3x3.sv
// rtl/sobel_edge_win3x3.sv - 3x3 window Sobel |Gx|+|Gy| threshold with border suppression
// Purpose : 3-stage free-running pipeline turning window strobes into edge-pixel strobes,
//           with frame position tracking and an end-of-frame pulse.
// Ports   : clk, rst_n (async, active-low), aclr (sync frame clear), win_en + p11..p33
//           (window in), threshold (per window), post_edge / post_en / frame_done (out).
// Config  : SOBEL_MAG_OUT_EN adds post_mag, the saturated magnitude (0 on border windows).
module sobel_edge_win3x3
    import sobel_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 aclr,
    input  logic                 win_en,
    input  logic [PIX_W-1:0]     p11,
    input  logic [PIX_W-1:0]     p12,
    input  logic [PIX_W-1:0]     p13,
    input  logic [PIX_W-1:0]     p21,
    input  logic [PIX_W-1:0]     p22,
    input  logic [PIX_W-1:0]     p23,
    input  logic [PIX_W-1:0]     p31,
    input  logic [PIX_W-1:0]     p32,
    input  logic [PIX_W-1:0]     p33,
    input  logic [MAG_W-1:0]     threshold,
    output logic                 post_edge,
    output logic                 post_en,
    output logic                 frame_done
`ifdef SOBEL_MAG_OUT_EN
    ,
    output logic [MAG_OUT_W-1:0] post_mag
`endif
);

    localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 2;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    // Tags travelling alongside the data through S1 and S2.
    logic             r_v1;
    logic             r_v2;
    logic             r_bord1;
    logic             r_bord2;
    logic             r_last1;
    logic             r_last2;
    logic [MAG_W-1:0] r_thr1;
    logic [MAG_W-1:0] r_thr2;

    logic             w_col_last;
    logic             w_row_last;
    logic             w_border;
    logic [SUM_W-1:0] w_gx;
    logic [SUM_W-1:0] w_gy;
    logic [MAG_W-1:0] w_mag;
    logic             w_edge;

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    // The first two rows/columns never see a full 3x3 neighbourhood of real pixels.
    assign w_border   = (r_row < ROW_W'(2)) | (r_col < COL_W'(2));

    // X axis: right column minus left column.
    sobel_axis_grad u_grad_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (aclr),
        .i_en_s1 (win_en),
        .i_en_s2 (r_v1),
        .i_a0    (p13),
        .i_a1    (p23),
        .i_a2    (p33),
        .i_b0    (p11),
        .i_b1    (p21),
        .i_b2    (p31),
        .o_abs   (w_gx)
    );

    // Y axis: bottom row minus top row.
    sobel_axis_grad u_grad_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (aclr),
        .i_en_s1 (win_en),
        .i_en_s2 (r_v1),
        .i_a0    (p31),
        .i_a1    (p32),
        .i_a2    (p33),
        .i_b0    (p11),
        .i_b1    (p12),
        .i_b2    (p13),
        .o_abs   (w_gy)
    );

    // Sum of two 12-bit magnitudes never exceeds MAG_MAX, so 13 bits cannot overflow.
    assign w_mag  = MAG_W'(w_gx) + MAG_W'(w_gy);
    assign w_edge = (w_mag >= r_thr2) & ~r_bord2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_bord1    <= 1'b0;
            r_bord2    <= 1'b0;
            r_last1    <= 1'b0;
            r_last2    <= 1'b0;
            r_thr1     <= '0;
            r_thr2     <= '0;
            post_en    <= 1'b0;
            post_edge  <= 1'b0;
            frame_done <= 1'b0;
        end else if (aclr) begin
            r_col      <= '0;
            r_row      <= '0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_bord1    <= 1'b0;
            r_bord2    <= 1'b0;
            r_last1    <= 1'b0;
            r_last2    <= 1'b0;
            r_thr1     <= '0;
            r_thr2     <= '0;
            post_en    <= 1'b0;
            post_edge  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // S1: position bookkeeping and tag capture with the window.
            if (win_en) begin
                r_bord1 <= w_border;
                r_last1 <= w_col_last & w_row_last;
                r_thr1  <= threshold;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            r_v1 <= win_en;

            // S2
            if (r_v1) begin
                r_bord2 <= r_bord1;
                r_last2 <= r_last1;
                r_thr2  <= r_thr1;
            end
            r_v2 <= r_v1;

            // S3: post_edge holds between results; frame_done is a strict pulse.
            post_en    <= r_v2;
            frame_done <= r_v2 & r_last2;
            if (r_v2) begin
                post_edge <= w_edge;
            end
        end
    end

`ifdef SOBEL_MAG_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_mag <= '0;
        end else if (aclr) begin
            post_mag <= '0;
        end else if (r_v2) begin
            post_mag <= r_bord2 ? '0 : sat_mag(w_mag);
        end
    end
`endif

endmodule

// File: tb/tb_sobel_edge_win3x3.sv
// tb/tb_sobel_edge_win3x3.sv - self-checking bench for sobel_edge_win3x3 on an 8x4 frame
module tb_sobel_edge_win3x3;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aclr = 1'b0;
    logic        win_en = 1'b0;
    logic [9:0]  wv [3][3];
    logic [12:0] threshold = '0;
    logic        post_edge;
    logic        post_en;
    logic        frame_done;
`ifdef SOBEL_MAG_OUT_EN
    logic [9:0]  post_mag;
`endif

    sobel_edge_win3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .aclr       (aclr),
        .win_en     (win_en),
        .p11        (wv[0][0]),
        .p12        (wv[0][1]),
        .p13        (wv[0][2]),
        .p21        (wv[1][0]),
        .p22        (wv[1][1]),
        .p23        (wv[1][2]),
        .p31        (wv[2][0]),
        .p32        (wv[2][1]),
        .p33        (wv[2][2]),
        .threshold  (threshold),
        .post_edge  (post_edge),
        .post_en    (post_en),
        .frame_done (frame_done)
`ifdef SOBEL_MAG_OUT_EN
        ,
        .post_mag   (post_mag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit edge_v;
        bit last;
        int mag;
    } exp_t;

    exp_t q[$];
    exp_t ce;
    int   cyc = 0;
    int   pos = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_en = 0;
    int   n_fd = 0;
    int   fd_at = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: 2-D convolution with the Sobel kernels over the current window.
    function automatic int model_mag();
        int kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
        int ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
        int gx = 0;
        int gy = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                gx += kx[r][c] * int'(wv[r][c]);
                gy += ky[r][c] * int'(wv[r][c]);
            end
        end
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return gx + gy;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int thr);
        exp_t e;
        int   m;
        bit   bord;
        m        = model_mag();
        bord     = ((pos / W) < 2) || ((pos % W) < 2);
        e.due    = cyc + 3;
        e.edge_v = !bord && (m >= thr);
        e.last   = (pos == NPIX - 1);
        e.mag    = bord ? 0 : ((m > 1023) ? 1023 : m);
        q.push_back(e);
        pos       = (pos + 1) % NPIX;
        threshold = 13'(thr);
        win_en    = 1'b1;
        tick();
        win_en    = 1'b0;
    endtask

    task automatic set_all(input int v);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                wv[r][c] = 10'(v);
    endtask

    task automatic set_step();
        for (int r = 0; r < 3; r++) begin
            wv[r][0] = 10'd0;
            wv[r][1] = 10'd1023;
            wv[r][2] = 10'd1023;
        end
    endtask

    task automatic set_corner();
        set_all(0);
        wv[0][0] = 10'd1023;
    endtask

    task automatic rand_win();
        int base;
        base = int'($urandom_range(0, 1023));
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 1) == 0) begin
                    wv[r][c] = 10'($urandom_range(0, 1023));
                end else begin
                    wv[r][c] = 10'((base + int'($urandom_range(0, 60))) % 1024);
                end
            end
        end
    endtask

    function automatic int pick_thr(input int mode);
        case (mode)
            0:       return 0;
            1:       return 8191;
            2:       return int'($urandom_range(0, 3000));
            default: return int'($urandom_range(0, 8191));
        endcase
    endfunction

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic finish_frame();
        while (pos != 0) begin
            rand_win();
            send(pick_thr(3));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
        end
        drain();
    endtask

    task automatic run_frame(input int mode);
        n_en  = 0;
        n_fd  = 0;
        fd_at = 0;
        for (int i = 0; i < NPIX; i++) begin
            rand_win();
            send(pick_thr(mode));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick();
        end
        drain();
        chk("frame_post_en_count", n_en, NPIX);
        chk("frame_done_count", n_fd, 1);
        chk("frame_done_on_last", fd_at, NPIX);
    endtask

    // Directed window with a literal expectation; also pins the 3-cycle latency.
    task automatic directed(input string nm, input int thr, input bit exp_edge);
        int lat;
        lat = -1;
        repeat (4) tick();
        send(thr);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (post_en) begin
                lat = i;
                break;
            end
        end
        chk({nm, "_latency"}, lat, 2);
        chk({nm, "_edge"}, post_edge, exp_edge);
        tick();
    endtask

    // Every-cycle comparison against the scoreboard.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            ce = q.pop_front();
            chk("post_en", post_en, 1);
            chk("post_edge", post_edge, ce.edge_v);
            chk("frame_done", frame_done, ce.last);
`ifdef SOBEL_MAG_OUT_EN
            chk("post_mag", post_mag, ce.mag);
`endif
        end else begin
            chk("post_en_idle", post_en, 0);
            chk("frame_done_idle", frame_done, 0);
        end
        if (post_en === 1'b1) n_en++;
        if (frame_done === 1'b1) begin
            n_fd++;
            fd_at = n_en;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        set_all(0);
        repeat (3) tick();
        chk("reset_post_en", post_en, 0);
        chk("reset_post_edge", post_edge, 0);
        chk("reset_frame_done", frame_done, 0);
        rst_n = 1'b1;
        tick();

        // Pin the reference model with hand-computed magnitudes.
        set_all(512);
        chk("model_flat", model_mag(), 0);
        set_step();
        chk("model_vstep", model_mag(), 4092);
        set_corner();
        chk("model_corner", model_mag(), 2046);

        // Frame 0: walk to row 2 col 2, then directed interior windows.
        repeat (18) begin
            rand_win();
            send(pick_thr(3));
        end
        set_all(512);
        directed("flat", 1, 1'b0);
        set_step();
        directed("vstep", 4000, 1'b1);
`ifdef SOBEL_MAG_OUT_EN
        chk("vstep_mag_sat", post_mag, 1023);
`endif
        set_corner();
        directed("corner_thr2", 2, 1'b1);
        directed("corner_thr2047", 2047, 1'b0);
        finish_frame();

        // Full frames with random gaps under several threshold regimes.
        run_frame(2);
        run_frame(0);
        run_frame(1);
        run_frame(3);

        // aclr mid-frame: two results in flight plus a window in the same cycle.
        repeat (10) begin
            rand_win();
            send(pick_thr(3));
        end
        rand_win();
        send(0);
        rand_win();
        send(0);
        aclr   = 1'b1;
        win_en = 1'b1;
        rand_win();
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due > cyc) q.delete(i);
        end
        pos = 0;
        tick();
        aclr   = 1'b0;
        win_en = 1'b0;
        set_step();
        directed("aclr_border", 0, 1'b0);
        finish_frame();
        run_frame(2);

        // Async reset mid-frame while an interior edge result is on the outputs.
        repeat (22) begin
            rand_win();
            send(0);
        end
        chk("pre_reset_post_en", post_en, 1);
        chk("pre_reset_post_edge", post_edge, 1);
        #2;
        rst_n = 1'b0;
        q.delete();
        pos = 0;
        #1;
        chk("async_reset_post_en", post_en, 0);
        chk("async_reset_post_edge", post_edge, 0);
        chk("async_reset_frame_done", frame_done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_frame(3);
        run_frame(0);

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
